// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline MEM stage (port A, priority)
// and the debug/loader port (port B, bounded wait). Read data returns one cycle after grant.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          pipe_stall,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = 4;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;
    typedef enum logic {NORMAL, STARVED} state_e;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    owner_e        rd_owner_q, rd_owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    state_e        state;

    // The arbitration state is fully captured by how long B has been refused.
    assign state = (wait_cnt_q == WAIT_MAX) ? STARVED : NORMAL;

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        mem_we     = 1'b0;
        wait_cnt_d = '0;
        rd_owner_d = OWN_NONE;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (!reset) begin
            if (state == STARVED && b_req) b_gnt = 1'b1;
            else if (a_req)                a_gnt = 1'b1;
            else if (b_req)                b_gnt = 1'b1;
        end

        if (a_gnt) begin
            addr_d     = a_addr;
            wdata_d    = a_wdata;
            mem_we     = a_we;
            rd_owner_d = a_we ? OWN_NONE : OWN_A;
        end else if (b_gnt) begin
            addr_d     = b_addr;
            wdata_d    = b_wdata;
            mem_we     = b_we;
            rd_owner_d = b_we ? OWN_NONE : OWN_B;
        end

        // Abandoning B (req dropped) or granting it both restart the wait window.
        if (b_req && !b_gnt)
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end

    assign pipe_stall = a_req & ~a_gnt & ~reset;
    assign mem_addr   = reset ? '0 : addr_d;
    assign mem_wdata  = reset ? '0 : wdata_d;

    assign a_rvalid = ~reset & (rd_owner_q == OWN_A);
    assign b_rvalid = ~reset & (rd_owner_q == OWN_B);
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration and memory contents.
module tb_dmem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, pipe_stall, b_gnt, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int n_chk = 0;
    int n_pass = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .pipe_stall(pipe_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural data_mem: registered read, write on the rising edge.
    logic [DW-1:0] ram [0:255];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model state
    int            m_wait;
    int            m_pend;        // 0 none, 1 A, 2 B
    logic [DW-1:0] m_pdata;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_wdata;
    logic          m_stall;
    logic [DW-1:0] mmem [0:15];

    task automatic set_a(input logic r, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_req = r; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic r, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_req = r; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_wait = 0; m_pend = 0; m_pdata = '0;
        m_last_addr = '0; m_last_wdata = '0; m_stall = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        set_a(1, 0, 16'h0001, '0);
        set_b(1, 0, 16'h0002, '0);
        #1;
        n_chk++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) $display("FAIL reset_gnt a=%0b b=%0b exp 0/0", a_gnt, b_gnt); else n_pass++;
        n_chk++; if (mem_we !== 1'b0 || pipe_stall !== 1'b0) $display("FAIL reset_we_stall we=%0b stall=%0b exp 0/0", mem_we, pipe_stall); else n_pass++;
        n_chk++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) $display("FAIL reset_rvalid a=%0b b=%0b exp 0/0", a_rvalid, b_rvalid); else n_pass++;
        @(negedge clock); #1;
        n_chk++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_memdrv addr=%h wdata=%h exp 0", mem_addr, mem_wdata); else n_pass++;
        n_chk++; if (a_rdata !== '0 || b_rdata !== '0) $display("FAIL reset_rdata a=%h b=%h exp 0", a_rdata, b_rdata); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_chk++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) $display("FAIL reset_release a=%0b b=%0b exp 1/0", a_gnt, b_gnt); else n_pass++;
    endtask

    task automatic test_a_read();
        apply_reset();
        @(negedge clock);
        set_b(1, 1, 16'h0010, 32'hDEADBEEF);
        #1;
        n_chk++; if (b_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010) $display("FAIL preload gnt=%0b we=%0b addr=%h exp 1/1/0010", b_gnt, mem_we, mem_addr); else n_pass++;
        @(negedge clock);
        set_b(0, 0, '0, '0);
        set_a(1, 0, 16'h0010, '0);
        #1;
        n_chk++; if (a_gnt !== 1'b1 || mem_we !== 1'b0) $display("FAIL a_read_gnt gnt=%0b we=%0b exp 1/0", a_gnt, mem_we); else n_pass++;
        @(negedge clock);
        set_a(0, 0, '0, '0);
        #1;
        n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) $display("FAIL a_read_data rv=%0b data=%h exp 1/deadbeef", a_rvalid, a_rdata); else n_pass++;
        n_chk++; if (b_rvalid !== 1'b0 || b_rdata !== '0) $display("FAIL a_read_b_quiet rv=%0b data=%h exp 0/0", b_rvalid, b_rdata); else n_pass++;
        n_chk++; if (mem_we !== 1'b0 || mem_addr !== 16'h0010) $display("FAIL idle_hold we=%0b addr=%h exp 0/0010", mem_we, mem_addr); else n_pass++;
        @(negedge clock); #1;
        n_chk++; if (a_rvalid !== 1'b0) $display("FAIL a_rvalid_once rv=%0b exp 0", a_rvalid); else n_pass++;
    endtask

    task automatic test_b_write_a_read();
        apply_reset();
        @(negedge clock);
        set_b(1, 1, 16'h0008, 32'h12345678);
        #1;
        n_chk++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678) $display("FAIL b_write we=%0b wdata=%h exp 1/12345678", mem_we, mem_wdata); else n_pass++;
        @(negedge clock);
        set_b(0, 0, '0, '0);
        set_a(1, 0, 16'h0008, '0);
        #1;
        n_chk++; if (mem_we !== 1'b0 || a_gnt !== 1'b1) $display("FAIL b_write_once we=%0b a_gnt=%0b exp 0/1", mem_we, a_gnt); else n_pass++;
        @(negedge clock);
        set_a(0, 0, '0, '0);
        #1;
        n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h12345678) $display("FAIL wr_then_rd rv=%0b data=%h exp 1/12345678", a_rvalid, a_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clock);
        set_a(1, 0, 16'h0010, '0);
        @(negedge clock);
        set_a(0, 0, '0, '0);
        set_b(1, 0, 16'h0008, '0);
        #1;
        n_chk++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_gnt !== 1'b1) $display("FAIL b2b_first rv=%0b data=%h bgnt=%0b exp 1/deadbeef/1", a_rvalid, a_rdata, b_gnt); else n_pass++;
        @(negedge clock);
        set_b(0, 0, '0, '0);
        #1;
        n_chk++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678 || a_rvalid !== 1'b0 || a_rdata !== '0) $display("FAIL b2b_second brv=%0b bdata=%h arv=%0b adata=%h exp 1/12345678/0/0", b_rvalid, b_rdata, a_rvalid, a_rdata); else n_pass++;
    endtask

    task automatic test_starvation();
        apply_reset();
        @(negedge clock);
        set_b(1, 1, 16'h0004, 32'hCAFE0004);
        @(negedge clock);
        set_a(1, 0, 16'h0020, '0);
        set_b(1, 0, 16'h0004, '0);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clock);
            #1;
            if (c == 5) begin
                n_chk++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || pipe_stall !== 1'b1) $display("FAIL starve_force c=%0d a=%0b b=%0b stall=%0b exp 0/1/1", c, a_gnt, b_gnt, pipe_stall); else n_pass++;
            end else begin
                n_chk++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || pipe_stall !== 1'b0) $display("FAIL starve_a c=%0d a=%0b b=%0b stall=%0b exp 1/0/0", c, a_gnt, b_gnt, pipe_stall); else n_pass++;
            end
        end
        n_chk++; if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFE0004) $display("FAIL starve_rdata rv=%0b data=%h exp 1/cafe0004", b_rvalid, b_rdata); else n_pass++;
        @(negedge clock);
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
    endtask

    task automatic test_abandon();
        int first_b;
        apply_reset();
        @(negedge clock);
        set_a(1, 0, 16'h0030, '0);
        set_b(1, 0, 16'h0004, '0);
        @(negedge clock);
        @(negedge clock);
        set_b(0, 0, '0, '0);
        #1;
        n_chk++; if (b_gnt !== 1'b0 || a_gnt !== 1'b1) $display("FAIL abandon_nognt a=%0b b=%0b exp 1/0", a_gnt, b_gnt); else n_pass++;
        first_b = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            set_b(1, 0, 16'h0004, '0);
            #1;
            if (b_gnt === 1'b1 && first_b == 0) first_b = c;
        end
        n_chk++; if (first_b != MAX_WAIT + 1) $display("FAIL abandon_wait first_b_cycle=%0d exp %0d", first_b, MAX_WAIT + 1); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int first_b;
        apply_reset();
        @(negedge clock);
        set_a(1, 0, 16'h0010, '0);
        set_b(1, 0, 16'h0004, '0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        #1;
        n_chk++; if (a_rvalid !== 1'b0 || a_rdata !== '0) $display("FAIL midrd_rst rv=%0b data=%h exp 0/0", a_rvalid, a_rdata); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_chk++; if (a_rvalid !== 1'b0) $display("FAIL midrd_after rv=%0b exp 0", a_rvalid); else n_pass++;
        set_a(1, 0, 16'h0010, '0);
        set_b(1, 0, 16'h0004, '0);
        first_b = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clock);
            #1;
            if (b_gnt === 1'b1 && first_b == 0) first_b = c;
        end
        n_chk++; if (first_b != MAX_WAIT + 1) $display("FAIL midrd_waitclr first_b_cycle=%0d exp %0d", first_b, MAX_WAIT + 1); else n_pass++;
    endtask

    task automatic test_random();
        logic starved, e_a, e_b, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int errs;
        apply_reset();
        errs = 0;
        for (int c = 0; c < 416; c++) begin
            @(negedge clock);
            if (c < 16) begin
                set_a(0, 0, '0, '0);
                set_b(1, 1, AW'(c), $urandom);
            end else begin
                if (!m_stall)
                    set_a($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom);
                set_b($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)), $urandom);
            end
            starved = b_req && (m_wait == MAX_WAIT);
            e_a     = a_req && !starved;
            e_b     = b_req && !e_a;
            m_stall = a_req && !e_a;
            e_we    = e_a ? a_we : (e_b ? b_we : 1'b0);
            e_addr  = e_a ? a_addr : (e_b ? b_addr : m_last_addr);
            e_wdata = e_a ? a_wdata : (e_b ? b_wdata : m_last_wdata);
            #1;
            n_chk++;
            if (a_gnt !== e_a || b_gnt !== e_b || pipe_stall !== m_stall || mem_we !== e_we
                || mem_addr !== e_addr || mem_wdata !== e_wdata
                || a_rvalid !== (m_pend == 1) || b_rvalid !== (m_pend == 2)
                || a_rdata !== ((m_pend == 1) ? m_pdata : '0) || b_rdata !== ((m_pend == 2) ? m_pdata : '0)) begin
                if (errs < 10)
                    $display("FAIL random c=%0d gnt=%0b%0b stall=%0b we=%0b addr=%h rv=%0b%0b ad=%h bd=%h exp gnt=%0b%0b stall=%0b we=%0b addr=%h pend=%0d data=%h",
                             c, a_gnt, b_gnt, pipe_stall, mem_we, mem_addr, a_rvalid, b_rvalid, a_rdata, b_rdata,
                             e_a, e_b, m_stall, e_we, e_addr, m_pend, m_pdata);
                errs++;
            end else n_pass++;
            // Advance the model by one transaction.
            m_pend = 0;
            if (e_a || e_b) begin
                m_last_addr  = e_addr;
                m_last_wdata = e_wdata;
                if (e_we) mmem[e_addr[3:0]] = e_wdata;
                else begin
                    m_pend  = e_a ? 1 : 2;
                    m_pdata = mmem[e_addr[3:0]];
                end
            end
            if (b_req && !e_b) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else               m_wait = 0;
        end
        @(negedge clock);
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_a_read();
        test_b_write_a_read();
        test_back_to_back();
        test_starvation();
        test_abandon();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d passed=%0d", n_chk, n_pass);
        $fatal(1, "timeout");
    end

endmodule
